// File: rtl/element_sum_tree.sv
// Combines NELEM element sample streams through a masked, registered binary adder tree.
// The output stage applies saturate/wrap arithmetic and keeps valid/busy aligned to the tree latency.
module element_sum_tree #(
    parameter int NELEM  = 8,
    parameter int NSLICE = 4,
    parameter int DW     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NELEM-1:0]           valid_in,
    input  logic [NELEM*NSLICE*DW-1:0] multix_in,
    input  logic [NELEM*NSLICE*DW-1:0] multiy_in,
    input  logic [NELEM-1:0]           enmask,
    input  logic                       satmode,
    input  logic                       ovf_clr,
    output logic                       valid,
    output logic [NSLICE*DW-1:0]       multix,
    output logic [NSLICE*DW-1:0]       multiy,
    output logic                       ovf_sticky,
    output logic [NELEM-1:0]           postprobusy
);
    localparam int L  = (NELEM > 1) ? $clog2(NELEM) : 0;
    localparam int NP = 1 << L;
    localparam int IW = DW + L;
    localparam logic signed [IW-1:0] MAXV = {{(L+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [IW-1:0] MINV = {{(L+1){1'b1}}, {(DW-1){1'b0}}};

    function automatic logic isOvf(input logic signed [IW-1:0] v);
        return (v > MAXV) || (v < MINV);
    endfunction

    function automatic logic [DW-1:0] fitSample(input logic signed [IW-1:0] v, input logic sat);
        logic [DW-1:0] res;
        if (sat && (v > MAXV))
            res = MAXV[DW-1:0];
        else if (sat && (v < MINV))
            res = MINV[DW-1:0];
        else
            res = v[DW-1:0];
        return res;
    endfunction

    // Masked, sign-extended inputs, zero-padded up to a power-of-two leaf count
    logic signed [IW-1:0] w_inX [NP][NSLICE];
    logic signed [IW-1:0] w_inY [NP][NSLICE];

    genvar ge, gs, gl;
    generate
        for (ge = 0; ge < NP; ge++) begin : g_pad
            for (gs = 0; gs < NSLICE; gs++) begin : g_sl
                if (ge < NELEM) begin : g_real
                    assign w_inX[ge][gs] = enmask[ge] ? IW'($signed(multix_in[(ge*NSLICE+gs)*DW +: DW])) : '0;
                    assign w_inY[ge][gs] = enmask[ge] ? IW'($signed(multiy_in[(ge*NSLICE+gs)*DW +: DW])) : '0;
                end else begin : g_zero
                    assign w_inX[ge][gs] = '0;
                    assign w_inY[ge][gs] = '0;
                end
            end
        end
    endgenerate

    logic [L:0] r_validPipe;
    logic [L:0] r_satPipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_validPipe <= '0;
            r_satPipe   <= '0;
        end else begin
            r_validPipe[0] <= |(valid_in & enmask);
            r_satPipe[0]   <= satmode;
            for (int k = 1; k <= L; k++) begin
                r_validPipe[k] <= r_validPipe[k-1];
                r_satPipe[k]   <= r_satPipe[k-1];
            end
        end
    end

    // Level 0 is the input register; each later level halves the node count
    generate
        for (gl = 0; gl <= L; gl++) begin : g_lvl
            localparam int N = NP >> gl;
            logic signed [IW-1:0] r_x [N][NSLICE];
            logic signed [IW-1:0] r_y [N][NSLICE];
            if (gl == 0) begin : g_in
                always_ff @(posedge clk) begin
                    for (int i = 0; i < N; i++) begin
                        for (int s = 0; s < NSLICE; s++) begin
                            if (reset) begin
                                r_x[i][s] <= '0;
                                r_y[i][s] <= '0;
                            end else begin
                                r_x[i][s] <= w_inX[i][s];
                                r_y[i][s] <= w_inY[i][s];
                            end
                        end
                    end
                end
            end else begin : g_add
                always_ff @(posedge clk) begin
                    for (int i = 0; i < N; i++) begin
                        for (int s = 0; s < NSLICE; s++) begin
                            if (reset) begin
                                r_x[i][s] <= '0;
                                r_y[i][s] <= '0;
                            end else begin
                                r_x[i][s] <= g_lvl[gl-1].r_x[2*i][s] + g_lvl[gl-1].r_x[2*i+1][s];
                                r_y[i][s] <= g_lvl[gl-1].r_y[2*i][s] + g_lvl[gl-1].r_y[2*i+1][s];
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    logic [NSLICE*DW-1:0] w_outX;
    logic [NSLICE*DW-1:0] w_outY;
    logic                 w_anyOvf;

    always_comb begin
        w_outX   = '0;
        w_outY   = '0;
        w_anyOvf = 1'b0;
        for (int s = 0; s < NSLICE; s++) begin
            w_outX[s*DW +: DW] = fitSample(g_lvl[L].r_x[0][s], r_satPipe[L]);
            w_outY[s*DW +: DW] = fitSample(g_lvl[L].r_y[0][s], r_satPipe[L]);
            w_anyOvf = w_anyOvf | isOvf(g_lvl[L].r_x[0][s]) | isOvf(g_lvl[L].r_y[0][s]);
        end
    end

    logic                 r_valid;
    logic [NSLICE*DW-1:0] r_multix;
    logic [NSLICE*DW-1:0] r_multiy;
    logic                 r_ovfSticky;

    // A fresh overflow takes priority over a coincident clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_multix    <= '0;
            r_multiy    <= '0;
            r_ovfSticky <= 1'b0;
        end else begin
            r_valid  <= r_validPipe[L];
            r_multix <= w_outX;
            r_multiy <= w_outY;
            if (r_validPipe[L] && w_anyOvf)
                r_ovfSticky <= 1'b1;
            else if (ovf_clr)
                r_ovfSticky <= 1'b0;
        end
    end

    assign valid       = r_valid;
    assign multix      = r_multix;
    assign multiy      = r_multiy;
    assign ovf_sticky  = r_ovfSticky;
    assign postprobusy = enmask & {NELEM{r_valid | (|r_validPipe)}};

endmodule

// File: doc/element_sum_tree.md
Name: element_sum_tree

Overview:
- Parametrised N-input combiner for the per-element DDS/envelope outputs of one DAC channel; replaces the fixed 4-/8-input summers.
- Sums NSLICE parallel 16-bit x/y samples from NELEM elements through a registered binary adder tree.
- Adds a per-element enable mask, selectable saturate/wrap output arithmetic, a sticky overflow flag, and valid/busy alignment to the tree latency.
- Sits between the element outputs and the DAC packer.

Parameters:
NELEM, 8, number of element inputs (1..32)
NSLICE, 4, samples per clock per element
DW, 16, sample width (signed two's complement)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
valid_in  input  NELEM  per-element valid (element e = bit e)
multix_in  input  NELEM*NSLICE*DW  x samples; element e slice s at [(e*NSLICE+s)*DW +: DW]
multiy_in  input  NELEM*NSLICE*DW  y samples, same packing
enmask  input  NELEM  element enable; 0 = element contributes zero and its valid is ignored
satmode  input  1  1 = saturate final sum to DW bits, 0 = wrap
ovf_clr  input  1  clears ovf_sticky
valid  output  1  output samples valid
multix  output  NSLICE*DW  summed x per slice
multiy  output  NSLICE*DW  summed y per slice
ovf_sticky  output  1  set when any output slice over/underflowed while valid
postprobusy  output  NELEM  per-element busy back to the element interface

Behaviour:
- One clock, clk. Reset is synchronous and active-high; all pipeline registers, valid, multix, multiy, ovf_sticky and postprobusy go to 0 on the cycle after reset is sampled high. A reset mid-pulse flushes all data in flight; there are no partial outputs after the reset.
- L = clog2(NELEM), with L = 0 when NELEM = 1. Internal width IW = DW+L; operands are sign-extended.
- Stage 0 (input register):
  - Latches each element's samples ANDed with enmask[e], and valid_in & enmask.
  - enmask and satmode are sampled only here and travel with the data.
  - Inputs are padded to 2^L with zeros.
- Stages 1..L: one registered pairwise-add level each.
  - Adjacent pairs (2k, 2k+1) are summed.
  - Full precision; no overflow possible inside the tree.
- Stage L+1 (output register):
  - satmode = 1: clamp IW sum to [-2^(DW-1), 2^(DW-1)-1].
  - satmode = 0: take the low DW bits.
  - Per-slice overflow flag = sum outside the DW range.
- Latency: input sampled at cycle t appears on multix/multiy at cycle t+L+2.
  - NELEM = 8 gives 5 cycles; NELEM = 1 gives 2 cycles.
- valid = OR of masked stage-0 valid, delayed L+1 further stages, aligned exactly with the data.
- Output samples are not gated by valid; they show the tree contents, which are 0 when all enabled inputs are 0.
- ovf_sticky:
  - Set on any cycle where valid = 1 and any slice, x or y, overflowed.
  - Cleared by ovf_clr.
  - Simultaneous set and clear: set wins.
  - Overflow while valid = 0 is ignored.
- postprobusy[e] = enmask[e] & (valid | any valid bit in flight in stages 0..L). Disabled elements report 0.
- No backpressure: a new sample is accepted every clock.

Test Plan:
- NELEM=8, NSLICE=4, all enabled. Drive element e with x = e+1, y = -(e+1), valid on all, for 1 cycle at t0 -> at t0+5 valid = 1 for exactly 1 cycle, every x slice = 36, every y slice = -36 (0xFFDC), ovf_sticky = 0.
- enmask = 8'b0000_0101, all elements x = 100, valid_in = 8'hFF -> output x = 200. Then set valid_in = 8'b0000_0010 only -> valid never asserts and postprobusy = 0.
- Overflow, satmode = 1: 4 elements x = 0x4000 -> output x = 0x7FFF and ovf_sticky = 1. Same stimulus with satmode = 0 -> output x = 0x0000 and ovf_sticky = 1. Pulse ovf_clr -> 0; ovf_clr coincident with a fresh overflow -> stays 1.
- Continuous 20-cycle pulse of ramp data on element 3 -> output is the ramp, 5 cycles late, with no gaps. postprobusy[3] is high from the first accept to the last valid; postprobusy[0] stays 0 when enmask[0] = 0.
- Assert reset for 1 cycle at t0+2 mid-pulse -> valid = 0 and outputs = 0 from t0+3 until new input propagates; ovf_sticky = 0.
- NELEM = 1 and NELEM = 5 (padding) builds -> latencies of 2 and 5 cycles; NELEM = 5 sum of x = 1000 each gives 5000.
